hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/rv_pipe_pkg.sv | 40 ++++
 rtl/opcode_class.sv | 42 ++++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants: RV32I major opcodes, forwarding-select encodings
// and the shadow-stage record used by the hazard controller.
package rv_pipe_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } stage_t;

    // MEM is the younger producer, so it takes precedence over WB.
    function automatic logic [1:0] fwd_pick(input logic used, input logic [4:0] src,
                                            input stage_t mem, input stage_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && src != 5'd0) begin
            if (mem.valid && mem.wr && mem.rd == src)
                sel = FWD_EXMEM;
            else if (wb.valid && wb.wr && wb.rd == src)
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: which register fields an instruction
// reads or writes, and whether it is a load.
module opcode_class
    import rv_pipe_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_load
);

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_OPIMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB in shadow registers to produce
// stall/flush/freeze controls, operand forwarding selects and perf counters.
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;
    logic             w_load_use;
    stage_t           r_ex, r_mem, r_wb;
    logic [4:0]       r_ex_rs1, r_ex_rs2;
    logic             r_ex_use1, r_ex_use2;
    logic             r_active;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    opcode_class u_opcode_class (
        .opcode    (id_opcode),
        .uses_rs1  (w_uses_rs1),
        .uses_rs2  (w_uses_rs2),
        .writes_rd (w_writes_rd),
        .is_load   (w_is_load)
    );

    assign w_load_use = id_valid && r_ex.valid && r_ex.ld && r_ex.wr && (r_ex.rd != 5'd0) &&
                        ((w_uses_rs1 && id_rs1_addr == r_ex.rd) ||
                         (w_uses_rs2 && id_rs2_addr == r_ex.rd));

    // r_active holds every output quiet for the first cycle after reset release.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        fwd_a_sel    = FWD_RF;
        fwd_b_sel    = FWD_RF;
        if (r_active) begin
            if (mem_busy) begin
                pipe_freeze = 1'b1;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            if (r_ex.valid) begin
                fwd_a_sel = fwd_pick(r_ex_use1, r_ex_rs1, r_mem, r_wb);
                fwd_b_sel = fwd_pick(r_ex_use2, r_ex_rs2, r_mem, r_wb);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_use1   <= 1'b0;
            r_ex_use2   <= 1'b0;
            r_active    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_active <= 1'b1;
            if (pc_stall)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (if_id_flush)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (!pipe_freeze) begin
                r_wb      <= r_mem;
                r_mem     <= r_ex;
                r_ex      <= '{valid: id_valid && !id_ex_bubble, rd: id_rd_addr,
                               wr: w_writes_rd, ld: w_is_load};
                r_ex_rs1  <= id_rs1_addr;
                r_ex_rs2  <= id_rs2_addr;
                r_ex_use1 <= w_uses_rs1;
                r_ex_use2 <= w_uses_rs2;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
